// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution front-end and kernels.
//   CONV_DATA_W  : default pixel width in bits
//   row_state_e  : row state of the 3x3 window generator
//                  FILL0  = first line of a frame (nothing buffered yet)
//                  FILL1  = second line (one line buffered)
//                  STREAM = third line onwards (full neighbourhood available)
// -----------------------------------------------------------------------------
package conv_pkg;

   localparam int CONV_DATA_W = 8;

   typedef enum logic [1:0] {
      FILL0  = 2'd0,
      FILL1  = 2'd1,
      STREAM = 2'd2
   } row_state_e;

endpackage : conv_pkg

// File: rtl/conv_window_3x3_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One image line of storage, read-before-write at a single shared address.
// The read is combinational, so in the cycle a pixel is written the old
// content of that column is still visible on rd_data.
// Contents are deliberately not reset; consumers mask stale data.
// Ports:
//   clk      in   clock, write on rising edge
//   wr_en    in   write wr_data to mem[addr] at the next rising edge
//   addr     in   ADDR_W  column address (read and write)
//   wr_data  in   DATA_W  data to store
//   rd_data  out  DATA_W  current content of mem[addr]
// -----------------------------------------------------------------------------
module line_buffer
   import conv_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int DATA_W = CONV_DATA_W,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   assign rd_data = mem_q[addr];

   // Synchronous write of one column; no reset on the storage array.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[addr] <= wr_data;
      end
   end

endmodule : line_buffer

// File: rtl/conv_window_3x3.sv
// -----------------------------------------------------------------------------
// conv_window_3x3
// Streaming 3x3 neighbourhood generator. A raster-order pixel stream is
// buffered over two lines and the nine pixels around the current position are
// presented on p1..p9. Only fully interior windows are flagged, so a W x H
// frame produces (W-2) x (H-2) out_valid pulses.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_pixel is accepted this cycle (no backpressure)
//   in_sof     in   with in_valid: pixel is row 0, col 0 of a new frame
//   in_pixel   in   DATA_W  pixel, raster order
//   out_valid  out  one-cycle pulse, p1..p9 hold a new interior window
//   p1..p9     out  DATA_W  window: p1-p3 row r-2, p4-p6 row r-1,
//                   p7-p9 row r; left to right col c-2, c-1, c
// -----------------------------------------------------------------------------
module conv_window_3x3
   import conv_pkg::*;
#(
   parameter int IMG_W  = 64,
   parameter int DATA_W = CONV_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic [DATA_W-1:0] in_pixel,
   output logic              out_valid,
   output logic [DATA_W-1:0] p1,
   output logic [DATA_W-1:0] p2,
   output logic [DATA_W-1:0] p3,
   output logic [DATA_W-1:0] p4,
   output logic [DATA_W-1:0] p5,
   output logic [DATA_W-1:0] p6,
   output logic [DATA_W-1:0] p7,
   output logic [DATA_W-1:0] p8,
   output logic [DATA_W-1:0] p9
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   localparam logic [COL_W-1:0] COL_ZERO = COL_W'(0);
   localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

   row_state_e        state_q;
   row_state_e        state_d;
   logic [COL_W-1:0]  col_q;
   logic [COL_W-1:0]  col_d;
   logic              out_valid_q;
   logic              out_valid_d;
   logic [DATA_W-1:0] win_q [9];
   logic [DATA_W-1:0] win_d [9];

   logic [COL_W-1:0]  lb_addr_s;
   logic [DATA_W-1:0] top_rd_s;
   logic [DATA_W-1:0] mid_rd_s;

   // lb_mid holds row r-1; on each accepted pixel it takes the new pixel while
   // its old content (row r-1) moves down into lb_top (row r-2).
   line_buffer #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W),
      .ADDR_W (COL_W)
   ) u_lb_mid (
      .clk     (clk),
      .wr_en   (in_valid),
      .addr    (lb_addr_s),
      .wr_data (in_pixel),
      .rd_data (mid_rd_s)
   );

   line_buffer #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W),
      .ADDR_W (COL_W)
   ) u_lb_top (
      .clk     (clk),
      .wr_en   (in_valid),
      .addr    (lb_addr_s),
      .wr_data (mid_rd_s),
      .rd_data (top_rd_s)
   );

   // A start-of-frame pixel always lands in column 0, wherever the old frame was.
   always_comb begin
      lb_addr_s = col_q;
      if (in_valid && in_sof) begin
         lb_addr_s = COL_ZERO;
      end else begin
         lb_addr_s = col_q;
      end
   end

   // Next-state logic: column counter, row state, window shift and output gate.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      out_valid_d = 1'b0;
      win_d       = win_q;

      if (in_valid) begin
         // Window shifts left by one column on every accepted pixel, including
         // masked border columns, so it is already primed when col reaches 2.
         win_d[0] = win_q[1];
         win_d[1] = win_q[2];
         win_d[2] = top_rd_s;
         win_d[3] = win_q[4];
         win_d[4] = win_q[5];
         win_d[5] = mid_rd_s;
         win_d[6] = win_q[7];
         win_d[7] = win_q[8];
         win_d[8] = in_pixel;

         if (in_sof) begin
            // Restart takes priority over any column wrap happening now.
            state_d     = FILL0;
            col_d       = COL_ONE;
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = (state_q == STREAM) && (col_q >= COL_TWO);
            if (col_q == COL_LAST) begin
               col_d = COL_ZERO;
               case (state_q)
                  FILL0:   state_d = FILL1;
                  FILL1:   state_d = STREAM;
                  STREAM:  state_d = STREAM;
                  default: state_d = FILL0;
               endcase
            end else begin
               col_d = col_q + COL_ONE;
            end
         end
      end else begin
         out_valid_d = 1'b0;
      end
   end

   // State, counter and output registers; reset clears everything except the
   // line buffers, whose stale content is masked by the row state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL0;
         col_q       <= COL_ZERO;
         out_valid_q <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         out_valid_q <= out_valid_d;
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= win_d[i];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign p1 = win_q[0];
   assign p2 = win_q[1];
   assign p3 = win_q[2];
   assign p4 = win_q[3];
   assign p5 = win_q[4];
   assign p6 = win_q[5];
   assign p7 = win_q[6];
   assign p8 = win_q[7];
   assign p9 = win_q[8];

endmodule : conv_window_3x3

// File: tb/tb_conv_window_3x3.sv
// -----------------------------------------------------------------------------
// tb_conv_window_3x3
// Self-checking bench for conv_window_3x3 with IMG_W = 4, DATA_W = 8.
// The reference model stores accepted pixels by (row, col) of the current frame
// and, for every pixel at row >= 2 and col >= 2, expects the 3x3 block of the
// frame ending at that pixel one cycle later.
// -----------------------------------------------------------------------------
module tb_conv_window_3x3;
   import conv_pkg::*;

   localparam int IMG_W  = 4;
   localparam int DATA_W = 8;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_sof;
   logic [DATA_W-1:0] in_pixel;
   logic              out_valid;
   logic [DATA_W-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
   logic [DATA_W-1:0] pv [9];

   int tests_run;
   int tests_failed;
   int pulses;
   int consec;
   logic prev_ov;

   // reference model state
   int m_r;
   int m_c;
   int img [3][IMG_W];

   conv_window_3x3 #(
      .IMG_W  (IMG_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_pixel  (in_pixel),
      .out_valid (out_valid),
      .p1        (p1),
      .p2        (p2),
      .p3        (p3),
      .p4        (p4),
      .p5        (p5),
      .p6        (p6),
      .p7        (p7),
      .p8        (p8),
      .p9        (p9)
   );

   assign pv[0] = p1;
   assign pv[1] = p2;
   assign pv[2] = p3;
   assign pv[3] = p4;
   assign pv[4] = p5;
   assign pv[5] = p6;
   assign pv[6] = p7;
   assign pv[7] = p8;
   assign pv[8] = p9;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      for (int k = 0; k < 9; k++) begin
         check_eq($sformatf("%s_p%0d", tag, k + 1), {24'd0, pv[k]}, 32'd0);
      end
   endtask

   // One cycle: drive at the falling edge, model the accept, check after the
   // following rising edge (at the next falling edge).
   task automatic step(input logic v, input logic s, input int pix);
      logic exp_v;
      int   ew [9];
      in_valid = v;
      in_sof   = s;
      in_pixel = pix[DATA_W-1:0];
      exp_v    = 1'b0;
      for (int k = 0; k < 9; k++) ew[k] = 0;
      if (v) begin
         if (s) begin
            m_r = 0;
            m_c = 0;
         end
         img[m_r % 3][m_c] = pix & 255;
         if (m_r >= 2 && m_c >= 2) begin
            exp_v = 1'b1;
            for (int rr = 0; rr < 3; rr++) begin
               for (int cc = 0; cc < 3; cc++) begin
                  ew[rr * 3 + cc] = img[(m_r - 2 + rr) % 3][m_c - 2 + cc];
               end
            end
         end
         m_c++;
         if (m_c == IMG_W) begin
            m_c = 0;
            m_r++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
      if (exp_v) begin
         for (int k = 0; k < 9; k++) begin
            check_eq($sformatf("p%0d", k + 1), {24'd0, pv[k]}, ew[k]);
         end
      end
      if (out_valid) pulses++;
      if (out_valid && prev_ov) consec++;
      prev_ov = out_valid;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      pulses       = 0;
      consec       = 0;
      prev_ov      = 1'b0;
      m_r          = 0;
      m_c          = 0;
      in_valid     = 1'b0;
      in_sof       = 1'b0;
      in_pixel     = '0;
      rst_n        = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // ramp frame 0..15 back-to-back
      pulses = 0;
      for (int i = 0; i < 16; i++) step(1'b1, i == 0, i);
      check_eq("ramp_pulses", pulses, 32'd4);

      // in_sof without in_valid while streaming: must change nothing
      step(1'b0, 1'b1, 77);
      step(1'b0, 1'b1, 78);

      // row 4 continues the frame: border masking at col 0/1
      pulses = 0;
      for (int i = 16; i < 20; i++) step(1'b1, 1'b0, i);
      check_eq("row4_pulses", pulses, 32'd2);

      // same ramp with in_valid low every other cycle
      pulses  = 0;
      consec  = 0;
      prev_ov = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, i == 0, i);
         step(1'b0, 1'b0, 200);
      end
      check_eq("gap_pulses", pulses, 32'd4);
      check_eq("gap_consecutive", consec, 32'd0);

      // mid-frame restart: sof on pixel 13 (value 100), then 11 more
      for (int i = 0; i < 13; i++) step(1'b1, i == 0, i);
      pulses = 0;
      step(1'b1, 1'b1, 100);
      for (int i = 1; i <= 11; i++) step(1'b1, 1'b0, 100 + i);
      check_eq("sof_mid_pulses", pulses, 32'd2);

      // asynchronous reset pulse after pixel 12
      for (int i = 0; i < 13; i++) step(1'b1, i == 0, i);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_zero_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      m_r = 0;
      m_c = 0;
      pulses = 0;
      for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 50 + i);
      check_eq("post_rst_pulses", pulses, 32'd1);

      // randomized traffic with occasional restarts, gaps and stray sof
      step(1'b1, 1'b1, $urandom_range(0, 255));
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 255));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_conv_window_3x3
